// File: rtl/alisim_pe_array.sv
// AliSim substitution core: a controller rotates a root word and feeds eight PEs that each apply one random substitution step.
// Latency: final_result_k is registered one clock after the nucl_alig_k / LFSR state it was computed from.
// Backpressure: none; every PE accepts a new word on every clock.

module alisim_peran #(
    parameter logic [31:0] LANE_SEED = 32'h0000_0001
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  nucl_alig,
    input  logic [159:0] matrix_P,
    output logic [31:0]  final_result
);
    logic [31:0] r_lfsr;
    logic [31:0] r_result;
    logic [31:0] w_lfsr_nxt;
    logic [31:0] w_word_nxt;
    logic [63:0] w_lfsr_dbl;
    logic [9:0]  w_rnd;
    logic [1:0]  w_x;
    logic [9:0]  w_thr;

    // Galois step; taps keep a nonzero state nonzero forever
    assign w_lfsr_nxt = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h8020_0003 : 32'h0000_0000);
    // the doubled word lets a plain slice act as rotate-right
    assign w_lfsr_dbl = {r_lfsr, r_lfsr};

    // all 16 nucleotides pick their first matching threshold column in parallel
    always_comb begin
        w_word_nxt = nucl_alig;
        w_rnd      = 10'd0;
        w_x        = 2'd0;
        w_thr      = 10'd0;
        for (int i = 0; i < 16; i++) begin
            w_x   = nucl_alig[2*i +: 2];
            w_rnd = w_lfsr_dbl[2*i +: 10];
            // walk columns high to low so the lowest matching column wins last
            for (int y = 3; y >= 0; y--) begin
                w_thr = matrix_P[40*int'(w_x) + 10*y +: 10];
                if (w_rnd < w_thr) begin
                    w_word_nxt[2*i +: 2] = y[1:0];
                end
            end
        end
    end

    // register the evolved word and advance the random source
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr   <= LANE_SEED;
            r_result <= 32'h0000_0000;
        end else begin
            r_lfsr   <= w_lfsr_nxt;
            r_result <= w_word_nxt;
        end
    end

    assign final_result = r_result;
endmodule

module alisim_pe_array #(
    parameter logic [31:0]  ROOT_SEQ = 32'h1B1B_1B1B,
    parameter logic [159:0] P_MATRIX = {4{10'd128, 10'd96, 10'd64, 10'd32}},
    parameter logic [31:0]  SEED     = 32'hACE1_ACE1
) (
    input  logic         clk,
    input  logic         reset,
    output logic [2:0]   pos_0, pos_1, pos_2, pos_3, pos_4, pos_5, pos_6, pos_7,
    output logic [31:0]  nucl_alig_0, nucl_alig_1, nucl_alig_2, nucl_alig_3,
    output logic [31:0]  nucl_alig_4, nucl_alig_5, nucl_alig_6, nucl_alig_7,
    output logic [159:0] matrix_P_0, matrix_P_1, matrix_P_2, matrix_P_3,
    output logic [159:0] matrix_P_4, matrix_P_5, matrix_P_6, matrix_P_7,
    output logic [31:0]  final_result_0, final_result_1, final_result_2, final_result_3,
    output logic [31:0]  final_result_4, final_result_5, final_result_6, final_result_7
);
    logic [31:0] r_root;
    logic [63:0] w_root_dbl;
    logic [31:0] w_nucl [8];
    logic [31:0] w_res   [8];

    // controller word advances by one nucleotide per clock; 16 clocks per full turn
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_root <= ROOT_SEQ;
        end else begin
            r_root <= {r_root[29:0], r_root[31:30]};
        end
    end

    // lane k sees the root rotated left by two nucleotides per lane index
    assign w_root_dbl = {r_root, r_root};

    for (genvar k = 0; k < 8; k++) begin : g_lane
        assign w_nucl[k] = w_root_dbl[63-4*k -: 32];

        alisim_peran #(
            .LANE_SEED (SEED + 32'(k))
        ) u_pe (
            .clk          (clk),
            .reset        (reset),
            .nucl_alig    (w_nucl[k]),
            .matrix_P     (P_MATRIX),
            .final_result (w_res[k])
        );
    end

    assign pos_0 = 3'd0;  assign pos_1 = 3'd1;  assign pos_2 = 3'd2;  assign pos_3 = 3'd3;
    assign pos_4 = 3'd4;  assign pos_5 = 3'd5;  assign pos_6 = 3'd6;  assign pos_7 = 3'd7;

    assign nucl_alig_0 = w_nucl[0];  assign nucl_alig_1 = w_nucl[1];
    assign nucl_alig_2 = w_nucl[2];  assign nucl_alig_3 = w_nucl[3];
    assign nucl_alig_4 = w_nucl[4];  assign nucl_alig_5 = w_nucl[5];
    assign nucl_alig_6 = w_nucl[6];  assign nucl_alig_7 = w_nucl[7];

    assign matrix_P_0 = P_MATRIX;  assign matrix_P_1 = P_MATRIX;
    assign matrix_P_2 = P_MATRIX;  assign matrix_P_3 = P_MATRIX;
    assign matrix_P_4 = P_MATRIX;  assign matrix_P_5 = P_MATRIX;
    assign matrix_P_6 = P_MATRIX;  assign matrix_P_7 = P_MATRIX;

    assign final_result_0 = w_res[0];  assign final_result_1 = w_res[1];
    assign final_result_2 = w_res[2];  assign final_result_3 = w_res[3];
    assign final_result_4 = w_res[4];  assign final_result_5 = w_res[5];
    assign final_result_6 = w_res[6];  assign final_result_7 = w_res[7];
endmodule

// File: tb/tb_alisim_pe_array.sv
// Bench for alisim_pe_array: three instances (identity, all-0x3FF, default matrix) against a reference model.
// Latency: checks are sampled 1 time unit after each rising edge.
// Backpressure: none; the bench drives only clock and reset.

module tb_alisim_pe_array;
    logic clk;
    logic reset;

    logic [2:0]   t_pos  [3][8];
    logic [31:0]  t_nucl [3][8];
    logic [159:0] t_mat  [3][8];
    logic [31:0]  t_res  [3][8];

    localparam logic [159:0] M_DEF = {4{10'd128, 10'd96, 10'd64, 10'd32}};
    localparam logic [159:0] M_FF  = {16{10'h3FF}};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam logic [159:0] M = (g == 0) ? 160'd0 : ((g == 1) ? M_FF : M_DEF);
        alisim_pe_array #(.P_MATRIX(M)) u_dut (
            .clk(clk), .reset(reset),
            .pos_0(t_pos[g][0]), .pos_1(t_pos[g][1]), .pos_2(t_pos[g][2]), .pos_3(t_pos[g][3]),
            .pos_4(t_pos[g][4]), .pos_5(t_pos[g][5]), .pos_6(t_pos[g][6]), .pos_7(t_pos[g][7]),
            .nucl_alig_0(t_nucl[g][0]), .nucl_alig_1(t_nucl[g][1]), .nucl_alig_2(t_nucl[g][2]),
            .nucl_alig_3(t_nucl[g][3]), .nucl_alig_4(t_nucl[g][4]), .nucl_alig_5(t_nucl[g][5]),
            .nucl_alig_6(t_nucl[g][6]), .nucl_alig_7(t_nucl[g][7]),
            .matrix_P_0(t_mat[g][0]), .matrix_P_1(t_mat[g][1]), .matrix_P_2(t_mat[g][2]),
            .matrix_P_3(t_mat[g][3]), .matrix_P_4(t_mat[g][4]), .matrix_P_5(t_mat[g][5]),
            .matrix_P_6(t_mat[g][6]), .matrix_P_7(t_mat[g][7]),
            .final_result_0(t_res[g][0]), .final_result_1(t_res[g][1]), .final_result_2(t_res[g][2]),
            .final_result_3(t_res[g][3]), .final_result_4(t_res[g][4]), .final_result_5(t_res[g][5]),
            .final_result_6(t_res[g][6]), .final_result_7(t_res[g][7])
        );
    end

    typedef struct {
        int          edges;
        int          lane;
        logic [31:0] nucl;
        logic [31:0] res;
    } vec_t;

    int n_checks;
    int n_pass;

    logic [159:0] mats    [3];
    logic [31:0]  m_root;
    logic [31:0]  m_lfsr  [8];
    logic [31:0]  exp_res [3][8];
    logic [31:0]  rec     [38][8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] w, input int n);
        logic [31:0] r;
        r = w;
        for (int s = 0; s < n; s++) r = {r[30:0], r[31]};
        return r;
    endfunction

    // independent reference of one PE step: nucleotide-serial first-match search
    function automatic logic [31:0] ref_step(input logic [31:0] w, input logic [31:0] l,
                                             input logic [159:0] m);
        logic [31:0] res;
        logic [31:0] rr;
        logic [1:0]  x;
        logic [9:0]  r;
        logic [9:0]  c;
        bit          found;
        res = w;
        for (int n = 0; n < 16; n++) begin
            x  = w[2*n +: 2];
            rr = l;
            for (int s = 0; s < 2*n; s++) rr = {rr[0], rr[31:1]};
            r = rr[9:0];
            found = 0;
            for (int y = 0; y < 4; y++) begin
                c = m[40*int'(x) + 10*y +: 10];
                if (!found && r < c) begin
                    res[2*n +: 2] = 2'(y);
                    found = 1;
                end
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] lfsr_adv(input logic [31:0] l);
        if (l[0]) return (l >> 1) ^ 32'h8020_0003;
        else      return l >> 1;
    endfunction

    task automatic model_reset();
        m_root = 32'h1B1B_1B1B;
        for (int k = 0; k < 8; k++) begin
            m_lfsr[k] = 32'hACE1_ACE1 + 32'(k);
            for (int g = 0; g < 3; g++) exp_res[g][k] = 32'h0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 8; k++)
            for (int g = 0; g < 3; g++)
                exp_res[g][k] = ref_step(rotl(m_root, 4*k), m_lfsr[k], mats[g]);
        for (int k = 0; k < 8; k++) m_lfsr[k] = lfsr_adv(m_lfsr[k]);
        m_root = rotl(m_root, 2);
    endtask

    task automatic check_reset(input string tag);
        for (int g = 0; g < 3; g++)
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("%s res g%0d k%0d", tag, g, k), 160'(t_res[g][k]), 160'd0);
                chk($sformatf("%s pos g%0d k%0d", tag, g, k), 160'(t_pos[g][k]), 160'(k));
                chk($sformatf("%s mat g%0d k%0d", tag, g, k), t_mat[g][k], mats[g]);
                chk($sformatf("%s nucl g%0d k%0d", tag, g, k), 160'(t_nucl[g][k]),
                    (k % 2 == 1) ? 160'h0B1B1_B1B1 : 160'h01B1B_1B1B);
            end
    endtask

    task automatic check_model(input int e);
        for (int g = 0; g < 3; g++)
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("res g%0d k%0d e%0d", g, k, e), 160'(t_res[g][k]), 160'(exp_res[g][k]));
                chk($sformatf("nucl g%0d k%0d e%0d", g, k, e), 160'(t_nucl[g][k]),
                    160'(rotl(m_root, 4*k)));
            end
    endtask

    initial begin
        vec_t vec [8];
        int   vi;
        n_checks = 0;
        n_pass   = 0;
        mats[0] = 160'd0;
        mats[1] = M_FF;
        mats[2] = M_DEF;

        // hand-computed identity-matrix vectors (instance 0), sorted by edge count
        vec[0] = '{0,  0, 32'h1B1B_1B1B, 32'h0000_0000};
        vec[1] = '{0,  1, 32'hB1B1_B1B1, 32'h0000_0000};
        vec[2] = '{1,  0, 32'h6C6C_6C6C, 32'h1B1B_1B1B};
        vec[3] = '{2,  0, 32'hB1B1_B1B1, 32'h6C6C_6C6C};
        vec[4] = '{2,  1, 32'h1B1B_1B1B, 32'hC6C6_C6C6};
        vec[5] = '{3,  5, 32'h6C6C_6C6C, 32'h1B1B_1B1B};
        vec[6] = '{16, 0, 32'h1B1B_1B1B, 32'hC6C6_C6C6};
        vec[7] = '{17, 7, 32'hC6C6_C6C6, 32'hB1B1_B1B1};

        // reset asserted, no clock edge yet
        reset = 1'b1;
        model_reset();
        #2;
        check_reset("rst0");
        reset = 1'b0;

        // first run: 37 edges, table vectors plus full model comparison
        vi = 0;
        for (int e = 0; e <= 37; e++) begin
            if (e > 0) begin
                @(posedge clk);
                #1;
                model_edge();
                check_model(e);
            end
            for (int k = 0; k < 8; k++) rec[e][k] = t_res[2][k];
            while (vi < 8 && vec[vi].edges == e) begin
                chk($sformatf("vec%0d nucl", vi), 160'(t_nucl[0][vec[vi].lane]), 160'(vec[vi].nucl));
                chk($sformatf("vec%0d res", vi), 160'(t_res[0][vec[vi].lane]), 160'(vec[vi].res));
                vi++;
            end
        end
        chk("vec table consumed", 160'(vi), 160'd8);

        // asynchronous reset between edges: outputs must clear without a clock
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_reset("rst37");
        #1;
        reset = 1'b0;

        // second run: 100 edges; the first 37 must replay the first run exactly
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk);
            #1;
            model_edge();
            check_model(e);
            if (e <= 37)
                for (int k = 0; k < 8; k++)
                    chk($sformatf("replay k%0d e%0d", k, e), 160'(t_res[2][k]), 160'(rec[e][k]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alisim_pe_array.md
# alisim_pe_array

Top-level substitution-simulation array for the AliSim FPGA datapath: a `Controller` front end broadcasts a root nucleotide word, lane IDs and a transition-threshold matrix to eight `PEran` processing elements. Each `PEran` evolves its 16-nucleotide word by one random substitution step per clock. The step uses a private LFSR. The block is the whole simulation core; the host observes all lanes' inputs and results.

## Interface
- `ROOT_SEQ`, default 32'h1B1B_1B1B: Controller root word ("ACGT" repeated; A=00, C=01, G=10, T=11; nucleotide i at bits [2i+1:2i]).
- `P_MATRIX`, default row x field y = 32*(y+1): 160-bit threshold matrix. Field (x,y) is at bits [40x+10y +: 10]; unsigned cumulative threshold out of 1024.
- `SEED`, default 32'hACE1_ACE1: LFSR base seed; lane k uses SEED+k; must be nonzero for every lane.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `pos_0..pos_7` out 3 each: lane ID of PE k.
- `nucl_alig_0..nucl_alig_7` out 32 each: nucleotide word fed to PE k.
- `matrix_P_0..matrix_P_7` out 160 each: matrix fed to PE k.
- `final_result_0..final_result_7` out 32 each: evolved word from PE k.
- One clock; reset is asynchronous and active-high (ports `clk`, `reset`).

## Operation
- **Controller:**
  - Holds 32-bit register R.
  - Reset: R = ROOT_SEQ.
  - Each clock after reset: R = rotate-left(R, 2).
  - Combinational outputs: nucl_alig_k = rotate-left(R, 4k); matrix_P_k = P_MATRIX; pos_k = k.
- **PEran (one per lane):**
  - Inputs `clk`, `reset`, `nucl_alig[31:0]`, `matrix_P[159:0]`; output `final_result[31:0]` (registered).
  - 32-bit Galois LFSR L. Reset: L = SEED+k. Each clock: L = {1'b0, L[31:1]} ^ (L[0] ? 32'h8020_0003 : 0).
  - For each nucleotide i in 0..15, using the current (pre-advance) L:
    - x = nucl_alig[2i+1:2i].
    - r_i = rotate-right(L, 2i)[9:0].
    - C_y = field (x,y).
    - New nucleotide = first y in 0..3 with r_i < C_y (unsigned). If none match, keep x.
  - All 16 lanes of nucleotides are computed combinationally in parallel and registered into final_result on the clock edge.
- No handshake: every PE consumes a new word every cycle. Thresholds are not required to be monotonic; first-match rule applies as stated.

## Timing
- Reset values:
  - R = ROOT_SEQ, so nucl_alig_0 = 0x1B1B1B1B and nucl_alig_1 = 0xB1B1B1B1; even lanes 0x1B1B1B1B, odd lanes 0xB1B1B1B1.
  - pos_k = k; matrix_P_k = P_MATRIX.
  - final_result_k = 0; L_k = SEED+k.
- Latency 1 cycle: final_result_k after edge n reflects nucl_alig_k and L_k present before edge n.
- R period: 16 cycles (full 32-bit rotation by 2), then the stream repeats.
- Reset asserted mid-run: all registers return to reset values immediately, without waiting for a clock edge. The first edge after deassertion behaves as edge 1.
- LFSR never reaches 0 for a nonzero seed. Seed 0 is illegal; behaviour is frozen r=0.

## Test plan
- Reset only, no clock edge -> final_result_k = 0; nucl_alig_0 = 0x1B1B1B1B, nucl_alig_1 = 0xB1B1B1B1; pos_k = k.
- P_MATRIX = 0 (identity), run 20 cycles -> every final_result_k equals nucl_alig_k of the previous cycle exactly. R after edge 1 = 0x6C6C6C6C, so final_result_0 after edge 2 = 0x6C6C6C6C.
- P_MATRIX all fields 10'h3FF, run 50 cycles -> each nucleotide becomes A (00) unless its r_i = 1023, in which case it is unchanged. Checked nucleotide-by-nucleotide against a reference model of L.
- Default P_MATRIX, SEED = 32'hACE1_ACE1, 100 cycles -> all lanes match a bit-exact software model (LFSR, rotation, first-match rule). Substitution rate ≈ 1/8 per nucleotide; lanes differ by seed.
- Assert reset asynchronously between edges at cycle 37 -> outputs return to reset values within the same cycle. The post-release sequence is identical to the first run.
- 17 consecutive cycles with identity matrix -> nucl_alig_0 returns to 0x1B1B1B1B after 16 edges (R wrap-around).
